// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-side memory responder: address width,
// responder FSM states and the fetch-stage NOP word.
package imem_responder_pkg;

    localparam int unsigned XLEN = 32;

    // Canonical RISC-V NOP (addi x0, x0, 0), shared with the fetch stage
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LOOKUP   = 2'd1,
        S_MISS_REQ = 2'd2,
        S_RESP     = 2'd3
    } state_t;

endpackage

// File: rtl/icache_array.sv
// Tag and data storage for the direct-mapped instruction cache: one synchronous
// read port and one write port, no reset so the arrays map onto block RAM.
module icache_array #(
    parameter int unsigned IDX_W = 6,
    parameter int unsigned TAG_W = 24
) (
    input  logic             i_clk,
    input  logic             i_rd_en,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [TAG_W-1:0] o_rd_tag,
    output logic [31:0]      o_rd_data,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  logic [31:0]      i_wr_data
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [TAG_W-1:0] r_tag_mem  [DEPTH];
    logic [31:0]      r_data_mem [DEPTH];
    logic [TAG_W-1:0] r_rd_tag;
    logic [31:0]      r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_tag_mem[i_wr_idx]  <= i_wr_tag;
            r_data_mem[i_wr_idx] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_tag  <= r_tag_mem[i_rd_idx];
            r_rd_data <= r_data_mem[i_rd_idx];
        end
    end

    assign o_rd_tag  = r_rd_tag;
    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/imem_responder.sv
// Fetch-side responder: direct-mapped one-word-per-line I-cache answering the
// fetch req/ack handshake, refilling misses over a single-outstanding read port.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int unsigned IDX_W = 6
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_inst_req,
    input  logic [XLEN-1:0] i_inst_req_addr,
    input  logic            i_stall_DDR2,
    input  logic            i_invalidate,
    output logic [31:0]     or_inst_data,
    output logic            or_inst_ack,
    output logic            or_mem_req,
    output logic [XLEN-1:0] or_mem_addr,
    input  logic [31:0]     i_mem_data,
    input  logic            i_mem_ack,
    output logic [31:0]     or_hit_count,
    output logic [31:0]     or_miss_count
);

    localparam int unsigned TAG_W = XLEN - IDX_W - 2;
    localparam int unsigned DEPTH = 1 << IDX_W;

    state_t           r_state;
    state_t           w_state_next;
    logic [XLEN-3:0]  r_req_addr;
    logic [DEPTH-1:0] r_valid;

    logic [IDX_W-1:0] w_req_idx;
    logic [TAG_W-1:0] w_req_tag;
    logic [TAG_W-1:0] w_rd_tag;
    logic [31:0]      w_rd_data;
    logic             w_addr_match;
    logic             w_hit;
    logic             w_rd_en;
    logic             w_lookup_hit;
    logic             w_lookup_miss;
    logic             w_issue;
    logic             w_fill;
    logic             w_fill_ack;
    logic             w_unused_addr_lsbs;

    assign w_req_idx          = r_req_addr[IDX_W-1:0];
    assign w_req_tag          = r_req_addr[XLEN-3:IDX_W];
    assign w_unused_addr_lsbs = ^i_inst_req_addr[1:0];

    // Fetch still wants the same word we latched in IDLE
    assign w_addr_match = i_inst_req && (i_inst_req_addr[XLEN-1:2] == r_req_addr);
    assign w_hit        = r_valid[w_req_idx] && !i_invalidate && (w_rd_tag == w_req_tag);

    icache_array #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .i_clk     (i_clk),
        .i_rd_en   (w_rd_en),
        .i_rd_idx  (i_inst_req_addr[IDX_W+1:2]),
        .o_rd_tag  (w_rd_tag),
        .o_rd_data (w_rd_data),
        .i_wr_en   (w_fill),
        .i_wr_idx  (w_req_idx),
        .i_wr_tag  (w_req_tag),
        .i_wr_data (i_mem_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_rd_en       = 1'b0;
        w_lookup_hit  = 1'b0;
        w_lookup_miss = 1'b0;
        w_issue       = 1'b0;
        w_fill        = 1'b0;
        w_fill_ack    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_inst_req) begin
                    w_rd_en      = 1'b1;
                    w_state_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (!w_addr_match) begin
                    w_state_next = S_IDLE;
                end else if (w_hit) begin
                    w_lookup_hit = 1'b1;
                    w_state_next = S_RESP;
                end else begin
                    w_lookup_miss = 1'b1;
                    w_state_next  = S_MISS_REQ;
                end
            end
            S_MISS_REQ: begin
                // Stall only gates issue; an outstanding read always completes
                if (or_mem_req) begin
                    if (i_mem_ack) begin
                        w_fill = 1'b1;
                        if (w_addr_match) begin
                            w_fill_ack   = 1'b1;
                            w_state_next = S_RESP;
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end
                end else if (!i_stall_DDR2) begin
                    w_issue = 1'b1;
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_req_addr    <= '0;
            r_valid       <= '0;
            or_inst_data  <= '0;
            or_inst_ack   <= 1'b0;
            or_mem_req    <= 1'b0;
            or_mem_addr   <= '0;
            or_hit_count  <= '0;
            or_miss_count <= '0;
        end else begin
            or_inst_ack <= w_lookup_hit || w_fill_ack;

            if (w_rd_en) begin
                r_req_addr <= i_inst_req_addr[XLEN-1:2];
            end

            if (w_lookup_hit) begin
                or_inst_data <= w_rd_data;
            end else if (w_fill_ack) begin
                or_inst_data <= i_mem_data;
            end

            if (w_issue) begin
                or_mem_req  <= 1'b1;
                or_mem_addr <= {r_req_addr, 2'b00};
            end else if (w_fill) begin
                or_mem_req <= 1'b0;
            end

            // Invalidate wins over a same-cycle fill: the line stays invalid
            if (i_invalidate) begin
                r_valid <= '0;
            end else if (w_fill) begin
                r_valid[w_req_idx] <= 1'b1;
            end

            if (w_lookup_hit && (or_hit_count != '1)) begin
                or_hit_count <= or_hit_count + 32'd1;
            end
            if (w_lookup_miss && (or_miss_count != '1)) begin
                or_miss_count <= or_miss_count + 32'd1;
            end
        end
    end

endmodule
